// File: rtl/mca_tree_as_multi.sv
// Time-multiplexed signed add/sub reduction of K coefficients per channel, NUM_ADDITIONS terms per clock.
// Optional output clamping with overflow flag when MCA_SATURATE_EN is defined; two's-complement wrap otherwise.
module mca_tree_as_multi #(
    parameter int unsigned K                 = 256,
    parameter int unsigned NUM_CH            = 1,
    parameter int unsigned WIDTH_COEFFICIENT = 32,
    parameter int unsigned NUM_ADDITIONS     = 16,
    parameter int unsigned WIDTH_OUT         = 32,
    parameter int unsigned OUT_SHIFT         = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic signed [WIDTH_COEFFICIENT-1:0] H_matrix [NUM_CH][K],
    input  logic        [K-1:0]                 S_matrix [NUM_CH],
    output logic                                busy,
    output logic                                sample_valid,
    output logic signed [WIDTH_OUT-1:0]         sample   [NUM_CH],
    output logic        [NUM_CH-1:0]            overflow
);

    localparam int unsigned NUM_BEATS = K / NUM_ADDITIONS;
    localparam int unsigned BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned IW        = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned AW        = WIDTH_COEFFICIENT + $clog2(K) + 1;
    // One guard bit above the wider of accumulator and output keeps clamp compares exact.
    localparam int unsigned RW        = ((AW > WIDTH_OUT) ? AW : WIDTH_OUT) + 1;

    if (K % NUM_ADDITIONS != 0) begin : g_bad_k
        $error("mca_tree_as_multi: K must be a multiple of NUM_ADDITIONS");
    end

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q, state_d;
    logic                   start_accept;
    logic                   last_beat;
    logic [BW-1:0]          beat_q;
    logic [K-1:0]           s_q       [NUM_CH];
    logic signed [AW-1:0]   acc_q     [NUM_CH];
    logic signed [AW-1:0]   beat_sum  [NUM_CH];
    logic signed [AW-1:0]   acc_next  [NUM_CH];
    logic signed [AW-1:0]   term;
    logic [IW-1:0]          idx;
    logic signed [RW-1:0]   r_ext     [NUM_CH];
    logic signed [WIDTH_OUT-1:0] res  [NUM_CH];
    logic [NUM_CH-1:0]      ovf;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        start_accept = 1'b0;
        last_beat    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                if (beat_q == BW'(NUM_BEATS - 1)) begin
                    last_beat = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Terms are sign-extended to the accumulator width before negation, so the most negative coefficient negates exactly.
    always_comb begin
        idx  = '0;
        term = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            beat_sum[c] = '0;
            for (int unsigned i = 0; i < NUM_ADDITIONS; i++) begin
                idx  = IW'(int'(beat_q) * int'(NUM_ADDITIONS) + int'(i));
                term = AW'(H_matrix[c][idx]);
                if (s_q[c][idx]) beat_sum[c] = beat_sum[c] + term;
                else             beat_sum[c] = beat_sum[c] - term;
            end
            acc_next[c] = acc_q[c] + beat_sum[c];
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_ext[c] = RW'(acc_next[c] >>> OUT_SHIFT);
`ifdef MCA_SATURATE_EN
            if (r_ext[c] > $signed({{(RW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}})) begin
                res[c] = {1'b0, {(WIDTH_OUT-1){1'b1}}};
                ovf[c] = 1'b1;
            end else if (r_ext[c] < $signed({{(RW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}})) begin
                res[c] = {1'b1, {(WIDTH_OUT-1){1'b0}}};
                ovf[c] = 1'b1;
            end else begin
                res[c] = r_ext[c][WIDTH_OUT-1:0];
                ovf[c] = 1'b0;
            end
`else
            res[c] = r_ext[c][WIDTH_OUT-1:0];
            ovf[c] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q       <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            overflow     <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                acc_q[c]  <= '0;
                s_q[c]    <= '0;
                sample[c] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (start_accept) begin
                beat_q <= '0;
                busy   <= 1'b1;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    acc_q[c] <= '0;
                    s_q[c]   <= S_matrix[c];
                end
            end else if (state_q == ACCUM) begin
                beat_q <= beat_q + 1'b1;
                for (int unsigned c = 0; c < NUM_CH; c++) acc_q[c] <= acc_next[c];
                if (last_beat) begin
                    beat_q       <= '0;
                    busy         <= 1'b0;
                    sample_valid <= 1'b1;
                    overflow     <= ovf;
                    for (int unsigned c = 0; c < NUM_CH; c++) sample[c] <= res[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_mca_tree_as_multi.sv
// Directed bench for mca_tree_as_multi: main instance plus OUT_SHIFT=4 and WIDTH_OUT=48 variants sharing stimulus.
module tb_mca_tree_as_multi;

    localparam int unsigned K  = 256;
    localparam int unsigned NC = 2;
    localparam int          LAT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic signed [31:0] h [NC][K];
    logic [K-1:0]       s [NC];

    logic               busy, sample_valid;
    logic signed [31:0] sample [NC];
    logic [NC-1:0]      overflow;
    logic               busy_sh, valid_sh;
    logic signed [31:0] sample_sh [NC];
    logic [NC-1:0]      overflow_sh;
    logic               busy_w, valid_w;
    logic signed [47:0] sample_w [NC];
    logic [NC-1:0]      overflow_w;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;

    always #5 clk = ~clk;

    mca_tree_as_multi #(.K(K), .NUM_CH(NC), .WIDTH_COEFFICIENT(32), .NUM_ADDITIONS(16),
                        .WIDTH_OUT(32), .OUT_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .H_matrix(h), .S_matrix(s),
        .busy(busy), .sample_valid(sample_valid), .sample(sample), .overflow(overflow));

    mca_tree_as_multi #(.K(K), .NUM_CH(NC), .WIDTH_COEFFICIENT(32), .NUM_ADDITIONS(16),
                        .WIDTH_OUT(32), .OUT_SHIFT(4)) dut_sh (
        .clk(clk), .reset(reset), .start(start), .H_matrix(h), .S_matrix(s),
        .busy(busy_sh), .sample_valid(valid_sh), .sample(sample_sh), .overflow(overflow_sh));

    mca_tree_as_multi #(.K(K), .NUM_CH(NC), .WIDTH_COEFFICIENT(32), .NUM_ADDITIONS(16),
                        .WIDTH_OUT(48), .OUT_SHIFT(0)) dut_w (
        .clk(clk), .reset(reset), .start(start), .H_matrix(h), .S_matrix(s),
        .busy(busy_w), .sample_valid(valid_w), .sample(sample_w), .overflow(overflow_w));

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge, then counts edges until sample_valid (bounded).
    task automatic run_op(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!sample_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic set_h_const(input logic signed [31:0] v);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < K; k++) h[c][k] = v;
    endtask

    task automatic set_h_ramp();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < K; k++) h[c][k] = 32'(k);
    endtask

    initial begin
        int nvalid;
        longint v0, v1;
        set_h_const(32'sd0);
        s[0] = '0;
        s[1] = '0;
        tick();
        tick();
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(sample_valid), 0);
        check("rst_sample", longint'(sample[0]), 0);
        check("rst_ovf", longint'(overflow), 0);
        reset = 1'b0;
        tick();

        // 1: +1 and -1 terms
        set_h_const(32'sd1);
        s[0] = '1;
        s[1] = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_after_accept", longint'(busy), 1);
        lat = 0;
        while (!sample_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("t1_latency", lat, LAT);
        check("t1_busy_at_valid", longint'(busy), 0);
        check("t1_ch0", longint'(sample[0]), 256);
        check("t1_ch1", longint'(sample[1]), -256);
        tick();
        check("t1_valid_one_cycle", longint'(sample_valid), 0);
        check("t1_hold", longint'(sample[0]), 256);

        // 2: ramp with alternating signs, then back-to-back start in the valid cycle
        set_h_ramp();
        for (int k = 0; k < K; k++) begin
            s[0][k] = (k % 2 == 0);
            s[1][k] = (k % 2 == 0);
        end
        run_op(lat);
        check("t2_latency", lat, LAT);
        check("t2_ch0", longint'(sample[0]), -128);
        check("t2_ch1", longint'(sample[1]), -128);
        s[0] = '1;
        s[1] = '0;
        run_op(lat);
        check("t2_b2b_latency", lat, LAT);
        check("t2_b2b_ch0", longint'(sample[0]), 32640);
        check("t2_b2b_ch1", longint'(sample[1]), -32640);

        // 3: ignored starts and S changes while busy
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        nvalid = 0;
        v0 = 0;
        v1 = 0;
        lat = 0;
        for (int t = 1; t <= 30; t++) begin
            start = (t == 3 || t == 10);
            if (t == 5) begin
                s[0] = '0;
                s[1] = '1;
            end
            tick();
            if (sample_valid) begin
                nvalid++;
                lat = t;
                v0 = longint'(sample[0]);
                v1 = longint'(sample[1]);
            end
        end
        start = 1'b0;
        check("t3_single_valid", nvalid, 1);
        check("t3_latency", lat, LAT);
        check("t3_ch0", v0, 32640);
        check("t3_ch1", v1, -32640);

        // 4: maximum positive coefficients
        set_h_const(32'sh7FFFFFFF);
        s[0] = '1;
        s[1] = '1;
        run_op(lat);
        check("t4_latency", lat, LAT);
`ifdef MCA_SATURATE_EN
        check("t4_sample", longint'(sample[0]), longint'(32'sh7FFFFFFF));
        check("t4_ovf", longint'(overflow), 3);
`else
        check("t4_sample", longint'(sample[0]), -256);
        check("t4_ovf", longint'(overflow), 0);
`endif

        // 5: reset mid-operation aborts, then a fresh op completes
        set_h_const(32'sd1);
        s[0] = '1;
        s[1] = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        nvalid = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (sample_valid) nvalid++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_no_valid_before_reset", nvalid, 0);
        check("t5_busy", longint'(busy), 0);
        check("t5_sample", longint'(sample[0]), 0);
        nvalid = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (sample_valid) nvalid++;
        end
        check("t5_no_valid_after_abort", nvalid, 0);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("t5_reset_beats_start", longint'(busy), 0);
        run_op(lat);
        check("t5_fresh_latency", lat, LAT);
        check("t5_fresh_ch0", longint'(sample[0]), 256);
        check("t5_fresh_ch1", longint'(sample[1]), -256);

        // 6: output shift and wider output
        check("t6_shift", longint'(sample_sh[0]), 16);
        check("t6_shift_neg", longint'(sample_sh[1]), -16);
        set_h_const(32'sh80000000);
        s[0] = '0;
        s[1] = '0;
        run_op(lat);
        check("t6_w48_ch0", longint'(sample_w[0]), longint'(1) << 39);
        check("t6_w48_ovf", longint'(overflow_w), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
